// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared constants and types for the shared-adder arbiter.
//   DATA_W  - adder datapath width
//   FLAG_W  - number of adder flags
//   FL_*    - bit positions of the flags in the packed vector {cout, of, sf, zf, cf}
package adder_share_pkg;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 5;

  localparam int FL_COUT = 4;
  localparam int FL_OF   = 3;
  localparam int FL_SF   = 2;
  localparam int FL_ZF   = 1;
  localparam int FL_CF   = 0;

  // Output stage occupancy
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} ostate_e;

  // Registered adder result
  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic [FLAG_W-1:0] flags;
  } add_rsp_t;
endpackage

// File: rtl/Adder32.sv
// Adder32: 32-bit adder with carry-in and status flags.
//   a, b, cin -> f = a + b + cin
//   cout : carry out of bit 31
//   of   : signed overflow
//   sf   : sign of f
//   zf   : f == 0
//   cf   : cout ^ cin (on subtract, 1 means borrow)
module Adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] f,
  output logic        cout,
  output logic        of,
  output logic        sf,
  output logic        zf,
  output logic        cf
);
  logic [32:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  assign f    = sum[31:0];
  assign cout = sum[32];
  // Overflow: both addends share a sign that the result does not
  assign of   = (a[31] == b[31]) && (f[31] != a[31]);
  assign sf   = f[31];
  assign zf   = (f == 32'b0);
  assign cf   = cout ^ cin;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req       - request vector
//   ptr       - index with highest priority this cycle
//   win       - first asserted index at or after ptr, wrapping mod N
//   any_valid - at least one request asserted (win is 0 otherwise)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          any_valid
);
  always_comb begin
    int idx;
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_valid && req[idx]) begin
        win       = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one Adder32 among NREQ requesters,
// with a one-entry registered output stage (zero-bubble drain/refill).
//   clk, rst               - clock, synchronous active-high reset
//   req_valid/req_ready    - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b           - operands, requester i at [32i+31:32i]
//   req_sub                - 1: A-B, 0: A+B
//   rsp_valid/rsp_ready    - result handshake
//   rsp_id, rsp_f, flags   - winner index, result and Adder32 flags
// Optional: ADDER_SHARE_ARB_PERF_EN adds perf_grant_cnt (NREQ x 16-bit
// saturating grant counters, requester i at [16i+15:16i]).
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_f,
  output logic                   rsp_cout,
  output logic                   rsp_of,
  output logic                   rsp_sf,
  output logic                   rsp_zf,
  output logic                   rsp_cf
`ifdef ADDER_SHARE_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]     perf_grant_cnt
`endif
);
  ostate_e          st_q, st_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   win;
  logic             any_valid;
  logic             can_accept;
  logic             hs;
  logic [DATA_W-1:0] op_a, op_b;
  logic             op_sub;
  add_rsp_t         add_out, rsp_q;
  logic [IDW-1:0]   id_q;

  rr_pick #(.N(NREQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .win       (win),
    .any_valid (any_valid)
  );

  assign can_accept = (st_q == ST_EMPTY) | rsp_ready;
  // Reset gates the grant so nothing is accepted during the reset cycle
  assign hs         = any_valid & can_accept & ~rst;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[win] = 1'b1;
  end

  // Operand mux; idle cycles drive zero
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    if (any_valid) begin
      op_sub = req_sub[win];
      op_a   = req_a[win*DATA_W +: DATA_W];
      op_b   = req_b[win*DATA_W +: DATA_W] ^ {DATA_W{op_sub}};
    end
  end

  Adder32 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_sub),
    .f    (add_out.f),
    .cout (add_out.flags[FL_COUT]),
    .of   (add_out.flags[FL_OF]),
    .sf   (add_out.flags[FL_SF]),
    .zf   (add_out.flags[FL_ZF]),
    .cf   (add_out.flags[FL_CF])
  );

  // Output stage occupancy
  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_EMPTY;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_EMPTY: if (hs) st_d = ST_FULL;
      ST_FULL:  if (!hs && rsp_ready) st_d = ST_EMPTY;
      default:  st_d = ST_EMPTY;
    endcase
  end

  // Data regs load only on a grant; a plain drain leaves them holding
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
    end else if (hs) begin
      rsp_q <= add_out;
      id_q  <= win;
      ptr_q <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

  assign rsp_valid = (st_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_f     = rsp_q.f;
  assign rsp_cout  = rsp_q.flags[FL_COUT];
  assign rsp_of    = rsp_q.flags[FL_OF];
  assign rsp_sf    = rsp_q.flags[FL_SF];
  assign rsp_zf    = rsp_q.flags[FL_ZF];
  assign rsp_cf    = rsp_q.flags[FL_CF];

`ifdef ADDER_SHARE_ARB_PERF_EN
  logic [NREQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (hs && win == IDW'(i) && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  assign perf_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized + directed bench for adder_share_arb,
// checked cycle by cycle against a behavioural model (round-robin search,
// one-entry output, arithmetic done with wide signed/unsigned integers).
module tb_adder_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, req_sub;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_f;
  logic                rsp_cout, rsp_of, rsp_sf, rsp_zf, rsp_cf;
`ifdef ADDER_SHARE_ARB_PERF_EN
  logic [NREQ*16-1:0]  perf_grant_cnt;
`endif

  adder_share_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_cout(rsp_cout), .rsp_of(rsp_of), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf), .rsp_cf(rsp_cf)
`ifdef ADDER_SHARE_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus, per requester
  logic [NREQ-1:0] v, s;
  logic [31:0]     a [NREQ];
  logic [31:0]     b [NREQ];

  always_comb begin
    req_valid = v;
    req_sub   = s;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = a[i];
      req_b[32*i +: 32] = b[i];
    end
  end

  // Model state
  int          mptr;
  logic        e_valid;
  logic [31:0] e_id;
  logic [31:0] e_f;
  logic [4:0]  e_flags;
  int          last_grant;
  int          cnt   [NREQ];
  int          waitg [NREQ];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {cout, of, sf, zf, cf, f} from integer arithmetic
  function automatic logic [36:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
    longint ux, uy, sx, sy, sr;
    logic [31:0] f;
    logic co, ov, cf;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      f  = x - y;
      co = (ux >= uy);
      cf = ~co;
      sr = sx - sy;
    end else begin
      f  = x + y;
      co = (ux + uy) > 64'hFFFF_FFFF;
      cf = co;
      sr = sx + sy;
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {co, ov, f[31], (f == 32'd0), cf, f};
  endfunction

  // One clock: check ready before the edge, advance model, check outputs after
  task automatic step();
    int win;
    logic found, hs;
    logic [NREQ-1:0] erdy;
    logic [36:0] r;
    #2;
    win = 0; found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (!found && v[(mptr + k) % NREQ]) begin
        win = (mptr + k) % NREQ;
        found = 1'b1;
      end
    hs   = found && (!e_valid || rsp_ready) && !rst;
    erdy = hs ? NREQ'(1) << win : '0;
    chk("req_ready", 64'(req_ready), 64'(erdy));
    @(posedge clk); #1;
    last_grant = -1;
    if (rst) begin
      e_valid = 0; e_id = 0; e_f = 0; e_flags = 0; mptr = 0;
      for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; waitg[i] = 0; end
    end else if (hs) begin
      r = ref_add(a[win], b[win], s[win]);
      e_valid = 1; e_id = win; e_f = r[31:0]; e_flags = r[36:32];
      mptr = (win + 1) % NREQ;
      last_grant = win;
      if (cnt[win] < 65535) cnt[win]++;
      chk("starve", 64'(waitg[win] > NREQ - 1), 64'd0);
      for (int i = 0; i < NREQ; i++)
        waitg[i] = (i == win || !v[i]) ? 0 : waitg[i] + 1;
    end else if (e_valid && rsp_ready) begin
      e_valid = 0;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("rsp_id",    64'(rsp_id),    64'(e_id));
    chk("rsp_f",     64'(rsp_f),     64'(e_f));
    chk("rsp_flags", 64'({rsp_cout, rsp_of, rsp_sf, rsp_zf, rsp_cf}), 64'(e_flags));
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_one(input int i, input logic [31:0] x, input logic [31:0] y, input logic sb);
    v = '0; v[i] = 1'b1; a[i] = x; b[i] = y; s[i] = sb;
  endtask

  task automatic rand_stim();
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && last_grant != i && ($urandom % 16) != 0) continue;
      if (($urandom % 8) < 5) begin
        v[i] = 1'b1; a[i] = rnd_op(); b[i] = rnd_op(); s[i] = $urandom % 2;
      end else begin
        v[i] = 1'b0;
      end
    end
    rsp_ready = ($urandom % 4) != 0;
  endtask

  logic [31:0] held_f;
  int          first_id;

  initial begin
    mptr = 0; e_valid = 0; e_id = 0; e_f = 0; e_flags = 0; last_grant = -1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 32'(i + 1); b[i] = 32'(i); cnt[i] = 0; waitg[i] = 0;
    end
    s = '0; v = '1; rsp_ready = 1'b1; rst = 1'b1;

    // Reset held two cycles with every requester asking
    step(); step();
    rst = 1'b0;
    step();
    chk("first_grant", 64'(rsp_id), 64'd0);

    // Add overflow into sign bit
    set_one(1, 32'h7FFF_FFFF, 32'h1, 1'b0); step();
    chk("add_id", 64'(rsp_id), 64'd1);
    chk("add_f",  64'(rsp_f),  64'h8000_0000);
    chk("add_fl", 64'({rsp_of, rsp_sf, rsp_zf, rsp_cout}), 64'b1100);
    // Equal subtract
    set_one(2, 32'd5, 32'd5, 1'b1); step();
    chk("sub0_f",  64'(rsp_f), 64'd0);
    chk("sub0_fl", 64'({rsp_zf, rsp_cout, rsp_cf}), 64'b110);
    // Borrow
    set_one(0, 32'd3, 32'd5, 1'b1); step();
    chk("subb_f",  64'(rsp_f), 64'hFFFF_FFFE);
    chk("subb_fl", 64'({rsp_sf, rsp_cf}), 64'b11);

    // Round-robin, all requesters continuously valid
    v = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) first_id = int'(rsp_id);
      chk("rr_order", 64'(rsp_id), 64'((first_id + k) % NREQ));
      chk("rr_valid", 64'(rsp_valid), 64'd1);
    end

    // Backpressure with req3 waiting
    held_f = rsp_f;
    set_one(3, 32'h1234_5678, 32'h1111_1111, 1'b0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold", 64'(rsp_f), 64'(held_f));
      chk("bp_rdy",  64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1; step();
    chk("bp_id",  64'(rsp_id), 64'd3);
    chk("bp_val", 64'(rsp_valid), 64'd1);

    // Reset while full and stalled
    v = '0; rsp_ready = 1'b0; step();
    rst = 1'b1; step();
    chk("mrst_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0; v = '1; rsp_ready = 1'b1; step();
    chk("mrst_ptr", 64'(rsp_id), 64'd0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rand_stim();
      step();
    end

`ifdef ADDER_SHARE_ARB_PERF_EN
    rst = 1'b1; step();
    rst = 1'b0;
    set_one(0, 32'd1, 32'd2, 1'b0); rsp_ready = 1'b1;
    for (int k = 0; k < 70000; k++) step();
    for (int k = 0; k < 200; k++) begin
      rand_stim();
      step();
    end
    chk("perf_sat0", 64'(perf_grant_cnt[15:0]), 64'hFFFF);
    for (int i = 1; i < NREQ; i++)
      chk($sformatf("perf%0d", i), 64'(perf_grant_cnt[16*i +: 16]), 64'(cnt[i]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Arbitrates one shared 32-bit adder (the team's Adder32) among NREQ requesters using round-robin.
- Each request carries operands and an add/sub op. The block drives the adder, registers F and flags (Cout/OF/SF/ZF/CF) in a one-entry output stage, and returns the result tagged with the requester ID.
- Sits between the multi-cycle execute units and the single adder instance.
- Full throughput: one grant per cycle when the response side is not stalled.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID. Localparam, derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- req_sub  in  NREQ  1 = A-B (B inverted, Cin=1); 0 = A+B (Cin=0).
- rsp_valid  out  1  registered result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index of the held result.
- rsp_f  out  32  sum/difference.
- rsp_cout, rsp_of, rsp_sf, rsp_zf, rsp_cf  out  1 each  adder flags, exactly as Adder32 produces them. CF = Cout^Cin, so CF=1 means borrow on sub.

Behaviour:
- Reset (rst=1 at edge): rsp_valid=0, rsp_id=0, rsp_f=0, all flags=0, rr pointer=0, req_ready=0 during reset cycle.
- Output stage states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready (combinational).
- Arbitration is combinational. It searches req_valid starting at index ptr, wrapping modulo NREQ; the first asserted index wins.
- req_ready[win] = can_accept; all other req_ready bits = 0. req_ready never depends on a different requester's ready.
- A handshake occurs when req_valid[i] & req_ready[i]. On that edge:
  - the output stage loads F/flags computed from the winner's operands;
  - rsp_id = win, rsp_valid = 1;
  - ptr = (win+1) mod NREQ.
- No handshake and rsp_valid & rsp_ready: rsp_valid goes to 0; data regs hold their last value.
- FULL & ~rsp_ready: all outputs stable; no grant; ptr unchanged.
- Simultaneous drain and fill (FULL, rsp_ready=1, winner present): the new result is loaded the same edge, rsp_valid stays 1. Zero-bubble.
- Latency: request accepted at edge N gives result visible after edge N (one cycle).
- Adder drive: A=req_a[win], B=req_b[win]^{32{req_sub[win]}}, Cin=req_sub[win]. When there is no winner, the operands are don't-care; drive zero.
- Requesters must hold valid/data stable until ready. The arbiter does not latch unaccepted requests.
- A requester dropping valid before grant is legal; it simply loses its turn.
- Wrap: win=NREQ-1 sets ptr=0.
- No requester can be starved: each waits at most NREQ-1 grants.
- Reset mid-operation discards a held result without a response. No pending request is remembered.

Optional Feature:
- Macro: ADDER_SHARE_ARB_PERF_EN.
- Defined: adds output perf_grant_cnt, NREQ*16, with per-requester 16-bit saturating grant counters.
  - Each counter increments on that requester's handshake and saturates at 16'hFFFF.
  - Counters clear on rst.
- Not defined: port and counters absent; all other behaviour identical.

Decomposition:
- Package adder_share_pkg holds:
  - DATA_W=32 and FLAG_W=5 localparams;
  - flag bit order {cout, of, sf, zf, cf}, as constant indices.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: win index, any_valid.
  - Reused later for other shared-unit arbiters.
- Top owns the Adder32 instance, the output register and ptr.

Test Plan:
- Reset check: hold rst 2 cycles with all req_valid=1 -> req_ready=0 during reset; after release rsp_valid=0, ptr=0, first grant goes to req 0.
- Add/sub flags:
  - req1 add 0x7FFFFFFF+0x00000001 -> rsp_id=1, F=0x80000000, OF=1, SF=1, ZF=0, Cout=0.
  - req2 sub 5-5 -> F=0, ZF=1, Cout=1, CF=0.
  - req0 sub 3-5 -> F=0xFFFFFFFE, SF=1, CF=1.
- Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... one per cycle, rsp_valid never drops.
- Backpressure: rsp_ready=0 for 3 cycles while req3 is valid -> rsp_* stable, req_ready=0. Then rsp_ready=1 -> same-edge drain and refill, with req3's result next.
- Reset mid-operation: assert rst while FULL and rsp_ready=0 -> rsp_valid=0 next cycle, held result discarded, ptr=0.
- Perf (macro defined): 70000 grants to req0 -> perf count for req0 = 0xFFFF (saturated); others equal their own grant counts.
